// File: rtl/dac_pkg.sv
// Shared types, widths and default timing for the DAC write sequencer.
package dac_pkg;
    localparam int ADDR_W        = 4;
    localparam int DATA_W        = 12;
    localparam int CMD_W         = ADDR_W + DATA_W;
    localparam int FRAME_LEN_DEF = 34;
    localparam int GAP_LEN_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } dac_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/dac_cmd_fifo.sv
// Command FIFO with power-of-two depth; pointers wrap naturally at DEPTH.
module dac_cmd_fifo
    import dac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/dac_write_sequencer.sv
// Drains queued DAC commands into fixed-length frames separated by a gap.
module dac_write_sequencer
    import dac_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int GAP_LEN   = GAP_LEN_DEF,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_data,
    output logic                   cmd_ready,
    output logic                   dac_start,
    output logic [ADDR_W-1:0]      dac_addr,
    output logic [DATA_W-1:0]      dac_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int CNT_W = $clog2(max_int(FRAME_LEN, GAP_LEN) + 1);

    dac_state_t       state_q;
    dac_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             load_en;
    logic             start_d;
    logic             frame_done;
    logic             gap_done;
    logic [CMD_W-1:0] fifo_head;

    dac_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata ({cmd_addr, cmd_data}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign frame_done = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign gap_done   = (cnt_q == CNT_W'(GAP_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: if (frame_done) state_d = ST_GAP;
            ST_GAP:  if (gap_done) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // dac_start is registered from the next state so it is high exactly while in SEND.
    always_comb begin
        fifo_pop = 1'b0;
        load_en  = 1'b0;
        cnt_d    = '0;
        start_d  = (state_d == ST_SEND);
        case (state_q)
            ST_LOAD: begin
                fifo_pop = 1'b1;
                load_en  = 1'b1;
            end
            ST_SEND: cnt_d = frame_done ? '0 : cnt_q + CNT_W'(1);
            ST_GAP:  cnt_d = gap_done ? '0 : cnt_q + CNT_W'(1);
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dac_start <= 1'b0;
            dac_addr  <= '0;
            dac_data  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dac_start <= start_d;
            if (load_en) {dac_addr, dac_data} <= fifo_head;
        end
    end
endmodule

// File: tb/tb_dac_write_sequencer.sv
// Randomized and directed bench for dac_write_sequencer against a frame-schedule model.
module tb_dac_write_sequencer;
    localparam int F  = 34;
    localparam int G  = 2;
    localparam int D  = 4;
    localparam int G2 = 1;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, dac_start, busy;
    logic [3:0]  cmd_addr, dac_addr;
    logic [11:0] cmd_data, dac_data;
    logic [2:0]  fifo_level;

    logic        rst_n_b, cmd_valid_b, cmd_ready_b, dac_start_b, busy_b;
    logic [3:0]  cmd_addr_b, dac_addr_b;
    logic [11:0] cmd_data_b, dac_data_b;
    logic [2:0]  fifo_level_b;

    int cyc = 0;
    bit chk_en = 1'b0;
    int checks = 0;
    int errors = 0;

    // Model: each accepted command has a push edge and a predicted frame-start edge.
    int          n_q[$];
    int          a_q[$];
    logic [15:0] c_q[$];
    int          last_a = -1000000;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          rise_q[$];
    logic        prev_start;

    always #5 clk = ~clk;

    dac_write_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .dac_start(dac_start),
        .dac_addr(dac_addr), .dac_data(dac_data), .busy(busy), .fifo_level(fifo_level)
    );

    dac_write_sequencer #(.FRAME_LEN(F), .GAP_LEN(G2), .DEPTH(D)) u_dut_gap1 (
        .clk(clk), .rst_n(rst_n_b), .cmd_valid(cmd_valid_b), .cmd_addr(cmd_addr_b),
        .cmd_data(cmd_data_b), .cmd_ready(cmd_ready_b), .dac_start(dac_start_b),
        .dac_addr(dac_addr_b), .dac_data(dac_data_b), .busy(busy_b), .fifo_level(fifo_level_b)
    );

    function automatic int m_level(input int e);
        int c = 0;
        foreach (n_q[k]) if (n_q[k] <= e && a_q[k] > e) c++;
        return c;
    endfunction

    function automatic logic m_start(input int e);
        foreach (a_q[k]) if (a_q[k] <= e && e <= a_q[k] + F - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_cmd(input int e);
        logic [15:0] r = 16'h0;
        foreach (a_q[k]) if (a_q[k] <= e) r = c_q[k];
        return r;
    endfunction

    // The block is busy from the LOAD cycle before a frame through the end of its gap.
    function automatic logic m_busy(input int e);
        if (m_level(e) > 0) return 1'b1;
        foreach (a_q[k]) if (a_q[k] - 1 <= e && e <= a_q[k] + F + G - 1) return 1'b1;
        return 1'b0;
    endfunction

    // A frame starts two edges after its push, but no sooner than one full period after the last.
    task automatic model_push(input int n, input logic [15:0] c);
        int a;
        a = n + 2;
        if (last_a + F + G + 1 > a) a = last_a + F + G + 1;
        n_q.push_back(n);
        a_q.push_back(a);
        c_q.push_back(c);
        last_a = a;
    endtask

    task automatic model_clear();
        n_q.delete();
        a_q.delete();
        c_q.delete();
        last_a = -1000000;
    endtask

    always @(negedge clk) begin
        logic [15:0] ec;
        int el;
        if (chk_en) begin
            el = m_level(cyc);
            ec = m_cmd(cyc);
            checks++;
            if (cmd_ready !== (el < D)) begin
                errors++;
                $display("FAIL cmd_ready cyc=%0d got=%b exp=%b", cyc, cmd_ready, (el < D));
            end
            checks++;
            if (fifo_level !== 3'(el)) begin
                errors++;
                $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, el);
            end
            checks++;
            if (dac_start !== m_start(cyc)) begin
                errors++;
                $display("FAIL dac_start cyc=%0d got=%b exp=%b", cyc, dac_start, m_start(cyc));
            end
            checks++;
            if ({dac_addr, dac_data} !== ec) begin
                errors++;
                $display("FAIL dac_addr_data cyc=%0d got=%h exp=%h", cyc, {dac_addr, dac_data}, ec);
            end
            checks++;
            if (busy !== m_busy(cyc)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy(cyc));
            end
            if (dac_start === 1'b1 && prev_start !== 1'b1) begin
                got_q.push_back({dac_addr, dac_data});
                rise_q.push_back(cyc);
            end
        end
        prev_start = dac_start;
    end

    task automatic drive_cycle(input logic v, input logic [3:0] a, input logic [11:0] d,
                               input logic r, output logic acc);
        int lvl;
        lvl = m_level(cyc);
        cmd_valid = v;
        cmd_addr  = a;
        cmd_data  = d;
        rst_n     = r;
        acc = r && v && (lvl < D);
        @(posedge clk);
        cyc++;
        if (!r) model_clear();
        else if (acc) model_push(cyc, {a, d});
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'h0, 12'h0, 1'b1, acc);
    endtask

    task automatic compare_frames(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_order idx=%0d got=%h exp=%h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic acc;
        drive_cycle(1'b1, 4'h5, 12'h123, 1'b0, acc);
        chk_en = 1'b1;
        drive_cycle(1'b1, 4'h6, 12'h456, 1'b0, acc);
        checks++;
        if ({dac_start, busy, cmd_ready} !== 3'b001 || fifo_level !== 3'd0 ||
            {dac_addr, dac_data} !== 16'h0) begin
            errors++;
            $display("FAIL reset_values got start=%b busy=%b ready=%b level=%0d ad=%h exp 0/0/1/0/0000",
                     dac_start, busy, cmd_ready, fifo_level, {dac_addr, dac_data});
        end
    endtask

    task automatic test_single();
        logic acc;
        int n, highs, first_hi, last_hi;
        idle(5);
        got_q.delete();
        rise_q.delete();
        n = cyc + 1;
        highs = 0;
        first_hi = -1;
        last_hi = -1;
        drive_cycle(1'b1, 4'd3, 12'hA5C, 1'b1, acc);
        for (int i = 0; i < 50; i++) begin
            idle(1);
            if (dac_start === 1'b1) begin
                highs++;
                if (first_hi < 0) first_hi = cyc;
                last_hi = cyc;
                checks++;
                if (dac_addr !== 4'd3 || dac_data !== 12'hA5C) begin
                    errors++;
                    $display("FAIL single_data cyc=%0d got=%h exp=3a5c", cyc, {dac_addr, dac_data});
                end
            end
        end
        checks++;
        if (first_hi != n + 2 || last_hi != n + 2 + F - 1 || highs != F) begin
            errors++;
            $display("FAIL single_frame got first=%0d last=%0d highs=%0d exp first=%0d last=%0d highs=%0d",
                     first_hi, last_hi, highs, n + 2, n + 2 + F - 1, F);
        end
    endtask

    task automatic test_burst();
        logic acc;
        logic [15:0] c;
        idle(10);
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        for (int i = 0; i < 4; i++) begin
            c = 16'($urandom());
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL burst_ready idx=%0d got=%b exp=1", i, cmd_ready);
            end
            drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
            exp_q.push_back(c);
        end
        idle(4 * (F + G + 1) + 10);
        compare_frames("burst");
        for (int i = 1; i < rise_q.size(); i++) begin
            checks++;
            if (rise_q[i] - rise_q[i-1] != F + G + 1) begin
                errors++;
                $display("FAIL burst_spacing idx=%0d got=%0d exp=%0d", i, rise_q[i] - rise_q[i-1], F + G + 1);
            end
        end
    endtask

    task automatic test_overflow();
        logic acc, obs;
        logic [15:0] c;
        int accepted, low_at, budget;
        idle(10);
        got_q.delete();
        exp_q.delete();
        c = 16'($urandom());
        exp_q.push_back(c);
        drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
        idle(5);
        accepted = 0;
        low_at = -1;
        budget = 0;
        c = 16'($urandom());
        while (accepted < 6 && budget < 300) begin
            obs = cmd_ready;
            if (!obs && low_at < 0) low_at = accepted;
            drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
            if (obs) begin
                exp_q.push_back(c);
                accepted++;
                c = 16'($urandom());
            end
            budget++;
        end
        checks++;
        if (accepted != 6) begin
            errors++;
            $display("FAIL overflow_timeout got=%0d accepted exp=6", accepted);
        end
        checks++;
        if (low_at != D) begin
            errors++;
            $display("FAIL overflow_ready_low got=%0d exp=%0d", low_at, D);
        end
        idle(7 * (F + G + 1) + 20);
        compare_frames("overflow");
    endtask

    task automatic test_mid_send_reset();
        logic acc;
        logic [15:0] c;
        int a;
        idle(10);
        for (int i = 0; i < 3; i++) begin
            c = 16'($urandom());
            drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
            if (i == 0) a = a_q[a_q.size() - 1];
        end
        while (cyc < a + 19) idle(1);
        checks++;
        if (dac_start !== 1'b1 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL midreset_pre got start=%b level=%0d exp start=1 level=2", dac_start, fifo_level);
        end
        drive_cycle(1'b0, 4'h0, 12'h0, 1'b0, acc);
        checks++;
        if (dac_start !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_post got start=%b level=%0d busy=%b exp 0/0/0", dac_start, fifo_level, busy);
        end
        rise_q.delete();
        idle(100);
        checks++;
        if (rise_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_frames got=%0d exp=0", rise_q.size());
        end
    endtask

    task automatic test_simul_push_pop();
        logic acc;
        logic [15:0] c;
        int a2;
        idle(10);
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            c = 16'($urandom());
            drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
            exp_q.push_back(c);
            if (i == 0) a2 = a_q[a_q.size() - 1] + F + G + 1;
        end
        while (cyc < a2 - 1) idle(1);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL simul_level_pre got=%0d exp=2", fifo_level);
        end
        c = 16'($urandom());
        drive_cycle(1'b1, c[15:12], c[11:0], 1'b1, acc);
        exp_q.push_back(c);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL simul_level_post got=%0d exp=2", fifo_level);
        end
        idle(4 * (F + G + 1) + 10);
        compare_frames("simul");
    endtask

    task automatic test_random();
        logic acc;
        logic [15:0] c;
        for (int i = 0; i < 800; i++) begin
            c = 16'($urandom());
            drive_cycle($urandom_range(0, 2) != 0, c[15:12], c[11:0], $urandom_range(0, 99) != 0, acc);
        end
        idle(5 * (F + G + 1) + 40);
        checks++;
        if (busy !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL random_drain got busy=%b level=%0d exp 0/0", busy, fifo_level);
        end
    endtask

    // With GAP_LEN=1, dac_start is also low during the one-cycle LOAD, so each low run is 2.
    task automatic test_gap1();
        logic [15:0] c, gb[$], eb[$];
        int hi_q[$], lo_q[$], rb[$];
        int sent, frames, hi_run, lo_run;
        logic obs, prev_b;
        rst_n_b = 1'b0;
        cmd_valid_b = 1'b0;
        idle(2);
        rst_n_b = 1'b1;
        sent = 0;
        frames = 0;
        hi_run = 0;
        lo_run = 0;
        prev_b = 1'b0;
        c = 16'($urandom());
        for (int i = 0; i < 6 * (F + G2 + 1) + 40; i++) begin
            cmd_valid_b = (sent < 6);
            {cmd_addr_b, cmd_data_b} = c;
            obs = cmd_ready_b;
            idle(1);
            if (obs && sent < 6) begin
                eb.push_back(c);
                sent++;
                c = 16'($urandom());
            end
            if (dac_start_b === 1'b1) begin
                if (!prev_b) begin
                    if (frames > 0) lo_q.push_back(lo_run);
                    frames++;
                    hi_run = 0;
                    gb.push_back({dac_addr_b, dac_data_b});
                    rb.push_back(cyc);
                end
                hi_run++;
            end else begin
                if (prev_b) begin
                    hi_q.push_back(hi_run);
                    lo_run = 0;
                end
                lo_run++;
            end
            prev_b = dac_start_b;
        end
        checks++;
        if (frames != 6 || hi_q.size() != 6 || lo_q.size() != 5) begin
            errors++;
            $display("FAIL gap1_frames got frames=%0d highs=%0d lows=%0d exp 6/6/5", frames, hi_q.size(), lo_q.size());
        end
        foreach (hi_q[i]) begin
            checks++;
            if (hi_q[i] != F) begin
                errors++;
                $display("FAIL gap1_high idx=%0d got=%0d exp=%0d", i, hi_q[i], F);
            end
        end
        foreach (lo_q[i]) begin
            checks++;
            if (lo_q[i] != G2 + 1 || rb[i+1] - rb[i] != F + G2 + 1) begin
                errors++;
                $display("FAIL gap1_low idx=%0d got low=%0d period=%0d exp low=%0d period=%0d",
                         i, lo_q[i], rb[i+1] - rb[i], G2 + 1, F + G2 + 1);
            end
        end
        foreach (gb[i]) begin
            checks++;
            if (i >= eb.size() || gb[i] !== eb[i]) begin
                errors++;
                $display("FAIL gap1_order idx=%0d got=%h", i, gb[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        rst_n_b = 1'b0;
        cmd_valid_b = 1'b0;
        cmd_addr_b = '0;
        cmd_data_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_mid_send_reset();
        test_simul_push_pop();
        test_random();
        test_gap1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog cyc=%0d exp completion before time limit", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
